// File: rtl/desynk_pkg.sv
// Shared types and constants for the edge-triggered glitch sequencer (edge_trigger_seq).
package desynk_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE,
    EDGE_FALL,
    EDGE_BOTH,
    EDGE_BOTH_ALT
  } edge_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_FIRE
  } state_e;

  // Flops ahead of the edge history when DESYNK_EDGE_SYNC_EN is defined.
  localparam int unsigned SYNC_DEPTH = 2;

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned sel_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_trigger_seq_if.sv
// Control, configuration and status bundle of edge_trigger_seq.
// The master side (arming agent) drives config; the slave side (sequencer) returns status.
interface edge_trigger_seq_if
  import desynk_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DLY_W    = 16,
  parameter int unsigned WID_W    = 8
);

  localparam int unsigned SEL_W = sel_width(CHANNELS);

  logic [CHANNELS-1:0] target;
  logic                arm;
  logic                abort;
  logic [SEL_W-1:0]    chan_sel;
  logic [1:0]          edge_mode;
  logic [CNT_W-1:0]    edge_count;
  logic [DLY_W-1:0]    delay;
  logic [WID_W-1:0]    width;
  logic                trigger;
  logic                armed;
  logic                done;

  modport master (
    output target, arm, abort, chan_sel, edge_mode, edge_count, delay, width,
    input  trigger, armed, done
  );

  modport slave (
    input  target, arm, abort, chan_sel, edge_mode, edge_count, delay, width,
    output trigger, armed, done
  );

endinterface

// File: rtl/edge_sampler.sv
// Per-channel edge detector: optional two-flop synchronizer (DESYNK_EDGE_SYNC_EN),
// one history flop, and rise/fall strobes relative to that history.
module edge_sampler
  import desynk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic level;
  logic hist_q;

`ifdef DESYNK_EDGE_SYNC_EN
  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], din_i};
    end
  end

  assign level = sync_q[SYNC_DEPTH-1];
`else
  assign level = din_i;
`endif

  // History updates in every state so a level held across arming never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= level;
    end
  end

  assign rise_o = level & ~hist_q;
  assign fall_o = ~level & hist_q;

endmodule

// File: rtl/edge_trigger_seq.sv
// One-shot glitch trigger sequencer: counts qualifying edges on a selected target line,
// waits a programmable delay, then emits a pulse. DESYNK_EDGE_SYNC_EN adds input synchronizers.
module edge_trigger_seq
  import desynk_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DLY_W    = 16,
  parameter int unsigned WID_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  edge_trigger_seq_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(CHANNELS);

  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_sampler u_sampler (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (bus.target[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  edge_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0] nlast_q, nlast_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [WID_W-1:0] wlast_q, wlast_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [DLY_W-1:0] dcnt_q, dcnt_d;
  logic [WID_W-1:0] wcnt_q, wcnt_d;
  logic             trigger_q, trigger_d;
  logic             armed_q, armed_d;
  logic             done_q, done_d;

  logic sel_rise;
  logic sel_fall;
  logic qual;

  assign sel_rise = rise[chan_q];
  assign sel_fall = fall[chan_q];

  always_comb begin
    qual = 1'b0;
    unique case (mode_q)
      EDGE_RISE: qual = sel_rise;
      EDGE_FALL: qual = sel_fall;
      default:   qual = sel_rise | sel_fall;
    endcase
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    mode_d  = mode_q;
    nlast_d = nlast_q;
    dly_d   = dly_q;
    wlast_d = wlast_q;
    ecnt_d  = ecnt_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.arm) begin
          chan_d  = (32'(bus.chan_sel) >= CHANNELS) ? '0 : bus.chan_sel;
          mode_d  = edge_mode_e'(bus.edge_mode);
          // Count and width are stored as "last index" so zero maps onto one for free.
          nlast_d = (bus.edge_count == '0) ? '0 : bus.edge_count - CNT_W'(1);
          dly_d   = bus.delay;
          wlast_d = (bus.width == '0) ? '0 : bus.width - WID_W'(1);
          ecnt_d  = '0;
          dcnt_d  = '0;
          wcnt_d  = '0;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (qual) begin
          if (ecnt_q == nlast_q) begin
            dcnt_d  = '0;
            wcnt_d  = '0;
            state_d = (dly_q == '0) ? ST_FIRE : ST_DELAY;
          end else if (ecnt_q != '1) begin
            ecnt_d = ecnt_q + CNT_W'(1);
          end
        end
      end
      ST_DELAY: begin
        if (dcnt_q == dly_q - DLY_W'(1)) begin
          wcnt_d  = '0;
          state_d = ST_FIRE;
        end else if (dcnt_q != '1) begin
          dcnt_d = dcnt_q + DLY_W'(1);
        end
      end
      ST_FIRE: begin
        if (wcnt_q == wlast_q) begin
          ecnt_d  = '0;
          dcnt_d  = '0;
          wcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (wcnt_q != '1) begin
          wcnt_d = wcnt_q + WID_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort) begin
      ecnt_d  = '0;
      dcnt_d  = '0;
      wcnt_d  = '0;
      state_d = ST_IDLE;
    end
  end

  // Outputs are flopped from the next state so they change exactly with the state.
  always_comb begin
    trigger_d = (state_d == ST_FIRE);
    armed_d   = (state_d == ST_ARMED) || (state_d == ST_DELAY);
    done_d    = (state_d == ST_FIRE) && (wcnt_d == wlast_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      chan_q    <= '0;
      mode_q    <= EDGE_RISE;
      nlast_q   <= '0;
      dly_q     <= '0;
      wlast_q   <= '0;
      ecnt_q    <= '0;
      dcnt_q    <= '0;
      wcnt_q    <= '0;
      trigger_q <= 1'b0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      mode_q    <= mode_d;
      nlast_q   <= nlast_d;
      dly_q     <= dly_d;
      wlast_q   <= wlast_d;
      ecnt_q    <= ecnt_d;
      dcnt_q    <= dcnt_d;
      wcnt_q    <= wcnt_d;
      trigger_q <= trigger_d;
      armed_q   <= armed_d;
      done_q    <= done_d;
    end
  end

  assign bus.trigger = trigger_q;
  assign bus.armed   = armed_q;
  assign bus.done    = done_q;

endmodule

// File: doc/edge_trigger_seq.md
Name: edge_trigger_seq

Overview:
- Parametrised successor to the single-channel edge detector in the glitch-trigger path.
- Watches CHANNELS target lines, selects one per arm, and counts qualifying edges (rise/fall/both).
- On the Nth qualifying edge, waits a programmable delay, then emits a trigger pulse of programmable width to the glitch generator.
- Configuration is latched at arm time; the block is one-shot per arm.

Parameters:
- CHANNELS, 4, number of target inputs (>=1).
- CNT_W, 16, width of edge-count field.
- DLY_W, 16, width of delay field, in clk cycles.
- WID_W, 8, width of pulse-width field, in clk cycles.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- target  in  CHANNELS  monitored lines.
- arm  in  1  level; sampled high in IDLE starts a sequence.
- abort  in  1  level; returns the block to IDLE from any state.
- chan_sel  in  $clog2(CHANNELS) (min 1)  channel to monitor.
- edge_mode  in  2  0=rise, 1=fall, 2=both, 3=both.
- edge_count  in  CNT_W  fire on this edge number; 0 treated as 1.
- delay  in  DLY_W  cycles between the qualifying edge and trigger rise.
- width  in  WID_W  trigger high cycles; 0 treated as 1.
- trigger  out  1  registered trigger pulse.
- armed  out  1  high in ARMED and DELAY.
- done  out  1  one-cycle pulse on the final trigger-high cycle.

Behaviour:
- Reset (rst_n low, async): state IDLE; trigger=0, armed=0, done=0; counters=0; history registers=0 (all target bits).
- Edge history: t_q <= target every cycle in every state, so stale levels never count as edges.
  - Edge for the selected channel c: rise = target[c] & ~t_q[c]; fall = ~target[c] & t_q[c].
- IDLE: on arm=1 (and abort=0), latch chan_sel, edge_mode, edge_count, delay, width; go to ARMED.
  - An edge in the arm cycle itself is not counted.
  - chan_sel >= CHANNELS latches as channel 0.
- ARMED: each qualifying edge increments ecnt.
  - When ecnt+1 == N_latched: go to FIRE if delay==0, else DELAY with dcnt=0.
  - Further target activity is ignored after leaving ARMED.
- DELAY: dcnt increments each cycle; when dcnt == delay-1, go to FIRE.
- FIRE: trigger=1; wcnt counts width cycles.
  - On the last cycle, done=1; next state IDLE with trigger=0.
- Latency, delay=0, sync off: trigger is high starting at the first clk edge that samples the qualifying target level, i.e. one cycle after the change.
  - delay=d adds exactly d cycles.
  - Pulse is exactly max(width,1) cycles.
- armed deasserts in the same cycle trigger rises.
- arm while not IDLE: ignored; arm held high after done re-arms on the next IDLE cycle.
- abort: highest priority, synchronous. Next cycle: IDLE, trigger=0, done=0, counters cleared. Reachable from any state, including mid-pulse.
- Counters saturate at field width.
  - edge_count = 2^CNT_W-1 is legal and must not wrap.
- Async reset mid-pulse drops trigger immediately.

Optional Feature:
- Macro: DESYNK_EDGE_SYNC_EN.
- Defined: each target bit passes through a two-flop synchronizer before edge history. Latency grows by 2 cycles (3 total at delay=0). Synchronizer flops reset to 0.
- Undefined: target is used directly (single history flop); latency is 1 cycle.

Decomposition:
- Package desynk_pkg holds:
  - typedef enum logic[1:0] edge_mode_e {EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_BOTH_ALT};
  - typedef enum state_e {ST_IDLE, ST_ARMED, ST_DELAY, ST_FIRE};
  - a localparam with the synchronizer depth.
- Sub-module edge_sampler (one instance per channel via generate): optional sync, history flop, rise/fall outputs.
- The top selects the channel and runs the FSM.

Test Plan:
- rise, N=1, delay=0, width=1, chan 0: arm, then drive target[0] 0->1 two cycles later -> trigger high exactly 1 cycle, 1 cycle after the change; done coincident with it.
- fall, N=3, delay=5, width=4, chan 2: three falling edges on target[2] and toggles on target[1] -> no trigger before the 3rd fall; trigger high 4 cycles starting 6 cycles after the 3rd fall; other channels ignored.
- both, N=2: 0->1 then 1->0 -> fire after the second edge. Also: edge coincident with the arm cycle is not counted (needs 2 further edges).
- abort: raised during DELAY, and again mid-pulse with width=10 -> trigger low the next cycle; state IDLE; a re-arm then works normally.
- edge_count=0, width=0 -> behaves as N=1 and width=1. arm pulsed during FIRE -> ignored; no second trigger.
- with DESYNK_EDGE_SYNC_EN: repeat scenario 1 -> trigger 3 cycles after the change. rst_n low mid-pulse -> trigger drops asynchronously.
